// File: rtl/v_hier_chan_mux.sv
// v_hier_chan_mux: round-robin merge of NCHAN FIFO-buffered valid/ready channels onto one tagged output
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : per-channel handshake, in_data channel k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready: registered output handshake, out_data word, out_chan source channel
//   busy               : any FIFO or the output register holds data
//   xfer_cnt           : saturating count of output transfers
module v_hier_chan_mux #(
    parameter int NCHAN = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCHAN-1:0]       in_valid,
    input  logic [NCHAN*WIDTH-1:0] in_data,
    output logic [NCHAN-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CHW-1:0]         out_chan,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [15:0]            xfer_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [NCHAN-1:0]            empty, full, push, pop;
    logic [NCHAN-1:0][WIDTH-1:0] heads;
    logic [CHW-1:0]              rr, grant;
    logic [CHW:0]                c;
    logic                        found, load;

    assign in_ready = ~full & {NCHAN{~rst}};
    assign load     = (~out_valid | out_ready) & ~&empty;
    assign busy     = out_valid | ~&empty;

    for (genvar k = 0; k < NCHAN; k++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW:0]      wr_ptr, rd_ptr;
        // Same index with differing wrap bit means the write pointer lapped the read pointer
        assign empty[k] = wr_ptr == rd_ptr;
        assign full[k]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign push[k]  = in_valid[k] & ~full[k];
        assign pop[k]   = load & (grant == CHW'(k));
        assign heads[k] = mem[rd_ptr[AW-1:0]];
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[k]) wr_ptr <= wr_ptr + (AW+1)'(1);
                if (pop[k]) rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        always_ff @(posedge clk)
            if (push[k]) mem[wr_ptr[AW-1:0]] <= in_data[k*WIDTH +: WIDTH];
    end

    // Scan channels rr, rr+1, ... (mod NCHAN); the first non-empty one wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        c     = '0;
        for (int i = 0; i < NCHAN; i++) begin
            c = {1'b0, rr} + (CHW+1)'(i);
            if (c >= (CHW+1)'(NCHAN)) c = c - (CHW+1)'(NCHAN);
            if (!found && !empty[c[CHW-1:0]]) begin
                found = 1'b1;
                grant = c[CHW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr        <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= heads[grant];
                out_chan  <= grant;
                rr        <= (grant == CHW'(NCHAN-1)) ? '0 : grant + 1'b1;
            end else if (out_ready) out_valid <= 1'b0;
            if (out_valid && out_ready && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
        end
endmodule

// File: tb/tb_v_hier_chan_mux.sv
// tb_v_hier_chan_mux: scoreboard bench for v_hier_chan_mux with default parameters
module tb_v_hier_chan_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [15:0] in_data = '0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] xfer_cnt;

    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [3:0] exp_q [4][$];
    logic [1:0] obs_chan [$];
    logic [3:0] obs_data [$];

    always #5 clk = ~clk;

    v_hier_chan_mux dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready),
        .busy(busy), .xfer_cnt(xfer_cnt)
    );

    // Scoreboard: accepted inputs are queued per channel, output transfers pop and compare
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (out_valid && out_ready) begin
                logic [3:0] e;
                n_checks++;
                if (exp_q[out_chan].size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: chan %0d data %h, no word expected", out_chan, out_data);
                end else begin
                    e = exp_q[out_chan].pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: chan %0d got %h expected %h", out_chan, out_data, e);
                    end
                end
                obs_chan.push_back(out_chan);
                obs_data.push_back(out_data);
            end
            for (int k = 0; k < 4; k++)
                if (in_valid[k] && in_ready[k]) exp_q[k].push_back(in_data[k*4 +: 4]);
        end
    end

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        obs_chan.delete();
        obs_data.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || xfer_cnt !== 16'h0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready %b out_valid %b xfer_cnt %h out_data %h, want 0000 0 0000 0",
                     in_ready, out_valid, xfer_cnt, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b1111 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready %b busy %b out_valid %b, want 1111 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 4'b0100;
        in_data = 16'h0A00;
        @(posedge clk);
        #1;
        in_valid = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_no_bypass: out_valid %b want 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_chan !== 2'd2) begin
            n_fail++;
            $display("FAIL single_word: valid %b data %h chan %0d, want 1 a 2", out_valid, out_data, out_chan);
        end
        @(negedge clk);
        n_checks++;
        if (xfer_cnt !== 16'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: xfer_cnt %0d valid %b busy %b, want 1 0 0", xfer_cnt, out_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_valid = 4'b1111;
            for (int k = 0; k < 4; k++) in_data[k*4 +: 4] = 4'(k*4 + j);
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (obs_chan.size() != 8 || xfer_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL rr_count: observed %0d xfer_cnt %0d, want 8 8", obs_chan.size(), xfer_cnt);
        end
        for (int i = 0; i < obs_chan.size() && i < 8; i++) begin
            n_checks++;
            if (obs_chan[i] !== 2'(i % 4) || obs_data[i] !== 4'((i % 4)*4 + i/4)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: chan %0d data %h, want chan %0d data %h",
                         i, obs_chan[i], obs_data[i], i % 4, 4'((i % 4)*4 + i/4));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] held;
        obs_chan.delete();
        obs_data.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'b0001;
            in_data = {12'h0, 4'(i)};
            @(negedge clk);
            n_checks++;
            if (in_ready[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_ready_word%0d: in_ready[0] %b want 1", i, in_ready[0]);
            end
            @(posedge clk);
            #1;
        end
        in_data = 16'h0005;
        held = out_data;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (in_ready[0] !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'h0 || out_chan !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_stall: in_ready[0] %b valid %b data %h chan %0d, want 0 1 0 0",
                         in_ready[0], out_valid, out_data, out_chan);
            end
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b0 || out_data !== held) begin
            n_fail++;
            $display("FAIL bp_release_edge: in_ready[0] %b data %h, want 0 %h", in_ready[0], out_data, held);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_after_pop: in_ready[0] %b want 1", in_ready[0]);
        end
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (obs_data.size() != 5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: observed %0d busy %b, want 5 0", obs_data.size(), busy);
        end
        for (int i = 0; i < obs_data.size() && i < 5; i++) begin
            n_checks++;
            if (obs_data[i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, obs_data[i], 4'(i));
            end
        end
    endtask

    task automatic test_saturation();
        int cycles = 0;
        mon_en = 1'b0;
        reset_dut();
        out_ready = 1'b1;
        in_valid = 4'b1111;
        in_data = 16'h7531;
        while (xfer_cnt !== 16'hFFFE && cycles < 70000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_checks++;
        if (xfer_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_reach: xfer_cnt %h, want fffe within budget", xfer_cnt);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: xfer_cnt %h want ffff", xfer_cnt);
        end
        in_valid = '0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            in_data = {8'h0, 4'(9 + i), 4'h0};
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_buffered: busy %b valid %b, want 1 1", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000 || xfer_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset: busy %b valid %b in_ready %b xfer_cnt %h, want 0 0 0000 0000",
                     busy, out_valid, in_ready, xfer_cnt);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        rst = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 4'b1111) begin
            n_fail++;
            $display("FAIL mid_ready_return: in_ready %b want 1111", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_emerge[%0d]: valid %b busy %b, want 0 0", i, out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/v_hier_chan_mux.md
Name: v_hier_chan_mux

Overview:
- Parametrised successor to the single-instance hierarchy top.
- Takes NCHAN independent WIDTH-bit input channels, each buffered in its own DEPTH-entry FIFO.
- Merges all channels onto one registered output stream using a round-robin arbiter, tagging each word with its source channel.
- Sits between per-channel sub-blocks and a shared downstream consumer; all interfaces use valid/ready handshakes.

Parameters:
- NCHAN, 4, number of input channels; legal range 1..16.
- WIDTH, 4, data width per channel; must be >= 1.
- DEPTH, 4, entries per channel FIFO; must be a power of 2 and >= 2.
- CHW, derived localparam = max(1, clog2(NCHAN)); width of out_chan.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NCHAN  per-channel valid; bit k belongs to channel k.
- in_data  input  NCHAN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  output  NCHAN  per-channel ready.
- out_valid  output  1  output word valid.
- out_data  output  WIDTH  output word.
- out_chan  output  CHW  source channel of out_data.
- out_ready  input  1  downstream accept.
- busy  output  1  high if any FIFO or the output register holds data.
- xfer_cnt  output  16  saturating count of output transfers.

Behaviour:
- Reset, asynchronous: all FIFOs empty; out_valid=0; out_data=0; out_chan=0; rr pointer=0; xfer_cnt=0; busy=0.
- in_ready[k] = ~full[k] & ~rst. This is combinational from registered state only, with no dependency on in_valid or out_ready.
- Input handshake: a write to FIFO k occurs when in_valid[k] & in_ready[k].
- Full FIFO: no write is accepted, even if an entry pops in the same cycle. in_ready rises the cycle after a pop.
- Per-channel FIFO: order is strictly preserved. Pointers are log2(DEPTH)+1 bits; full/empty are decoded from the MSB compare, and pointers wrap modulo 2*DEPTH.
- Output register: a single stage.
  - Loads when (~out_valid | out_ready) and at least one FIFO is non-empty.
  - On load: pop the granted FIFO head into out_data and set out_chan=k, out_valid=1.
  - If the stage frees up and no FIFO is non-empty, out_valid drops to 0.
- Output holding: while out_valid & ~out_ready, out_data and out_chan hold stable and no pop occurs.
- Latency: a word written at edge N can appear with out_valid=1 after edge N+1 at the earliest.
- Throughput: with out_ready held high, one word per cycle.
- Arbitration is round-robin.
  - The search starts at the rr pointer and checks channels rr, rr+1, ... modulo NCHAN.
  - The first non-empty channel wins.
  - After a grant to channel k, rr becomes (k+1) mod NCHAN.
  - rr is unchanged when no grant is made.
- Same FIFO written and popped in the same cycle (non-full): both take effect and occupancy is unchanged.
- Empty FIFO written in cycle N: it is not eligible for grant until cycle N+1; there is no bypass path.
- xfer_cnt increments on out_valid & out_ready and saturates at 16'hFFFF.
- busy = out_valid | any FIFO non-empty.
- NCHAN=1: the arbiter degenerates, out_chan is constantly 0, and rr stays 0.
- Reset mid-operation: all buffered and in-flight words are discarded immediately. in_ready is forced low while rst=1 and returns high on the first cycle after deassertion.

Test Plan:
- Reset check: rst asserted -> in_ready=0, out_valid=0, xfer_cnt=0. After rst deasserts -> in_ready=4'b1111, busy=0.
- Single word: out_ready=1; push ch2 data 4'hA at edge N -> out_valid=1, out_data=4'hA, out_chan=2 after edge N+1; xfer_cnt=1.
- Round-robin fairness: out_ready=1; all 4 channels hold 2 words each (ch k words = {k,0} and {k,1}, 4-bit) -> output channel order 0,1,2,3,0,1,2,3; per-channel order preserved; xfer_cnt=8.
- Backpressure and full, in order:
  - out_ready=0; push 5 words to ch0 -> in_ready[0] drops after 4 FIFO entries plus 1 in the output register.
  - out_data stays stable while stalled.
  - Release out_ready -> words emerge in order 0..4.
- Saturation and reset: preload xfer_cnt near 16'hFFFE and run 5 transfers -> count holds 16'hFFFF. Assert rst with 3 words buffered -> busy=0 and no word emerges after reset.
